// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2**ADDR_W x DATA_W register file, two read ports, debug port, write counter
// Optional same-cycle write-through forwarding: define REG_FILE_BYPASS_EN.
module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       wr_count
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [15:0]       wr_count_q;
   logic [15:0]       wr_count_d;
   logic              wr_en;

   // x0 is never written, so its flop stays at its reset value of zero
   assign wr_en = RegWrite && (rd != '0);

   always_comb begin
      regs_d     = regs_q;
      wr_count_d = wr_count_q;
      if (wr_en) begin
         regs_d[rd] = WriteData;
         wr_count_d = wr_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wr_count_q <= '0;
      end else begin
         regs_q     <= regs_d;
         wr_count_q <= wr_count_d;
      end
   end

   always_comb begin
      ReadData1 = regs_q[rs1];
      ReadData2 = regs_q[rs2];
      dbg_data  = regs_q[dbg_addr];
`ifdef REG_FILE_BYPASS_EN
      // Forward the in-flight write so the same-cycle consumer sees the new value
      if (wr_en) begin
         if (rs1 == rd)      ReadData1 = WriteData;
         if (rs2 == rd)      ReadData2 = WriteData;
         if (dbg_addr == rd) dbg_data  = WriteData;
      end
`endif
      // Zero masking last: overrides both storage and any forwarded value
      if (rs1 == '0 || !rst_n)      ReadData1 = '0;
      if (rs2 == '0 || !rst_n)      ReadData2 = '0;
      if (dbg_addr == '0 || !rst_n) dbg_data  = '0;
   end

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against an array-based model
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        RegWrite = 1'b0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, dbg_addr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData1, ReadData2, dbg_data;
   logic [15:0] wr_count;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] mem [32];
   int unsigned cnt = 0;

   reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite),
      .rs1(rs1), .rs2(rs2), .rd(rd), .WriteData(WriteData),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(input int a);
      if (!rst_n || a == 0) return 32'h0;
      if (BYP && RegWrite && rd != 0 && int'(rd) == a) return WriteData;
      return mem[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      cnt = 0;
   endtask

   // One clock: drive at negedge, check comb reads before the edge, commit, check counter
   task automatic cycle(input bit we, input int wa, input logic [31:0] wd,
                        input int a1, input int a2, input int ad);
      @(negedge clk);
      RegWrite = we; rd = 5'(wa); WriteData = wd;
      rs1 = 5'(a1); rs2 = 5'(a2); dbg_addr = 5'(ad);
      #1;
      chk("rd1", ReadData1, model_rd(a1));
      chk("rd2", ReadData2, model_rd(a2));
      chk("dbg", dbg_data,  model_rd(ad));
      @(posedge clk);
      if (we && wa != 0) begin
         mem[wa] = wd;
         cnt = cnt + 1;
      end
      #1;
      chk("wr_count", {16'h0, wr_count}, cnt & 32'hFFFF);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, w, r1;
      model_reset();
      #1 rst_n = 1'b0;

      // Reset sweep with a write attempted on an edge while reset is held
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(i); dbg_addr = 5'(i);
         #1;
         chk("rst_rd1", ReadData1, 32'h0);
         chk("rst_rd2", ReadData2, 32'h0);
         chk("rst_dbg", dbg_data, 32'h0);
      end
      RegWrite = 1'b1; rd = 5'd4; WriteData = 32'h12345678;
      @(posedge clk); #1;
      chk("rst_wr_count", {16'h0, wr_count}, 32'h0);
      @(negedge clk);
      RegWrite = 1'b0; rs1 = 5'd4;
      rst_n = 1'b1;
      #1 chk("rst_write_dropped", ReadData1, 32'h0);

      // Basic write/read and x0 discard
      cycle(1, 5, 32'hDEADBEEF, 0, 0, 0);
      cycle(0, 0, 32'h0, 5, 0, 5);
      chk("w5_lit", ReadData1, 32'hDEADBEEF);
      chk("w5_count", {16'h0, wr_count}, 32'h1);
      cycle(1, 0, 32'hFFFFFFFF, 0, 0, 0);
      cycle(0, 0, 32'h0, 5, 0, 0);
      chk("x0_lit", ReadData2, 32'h0);
      chk("x0_count", {16'h0, wr_count}, 32'h1);

      // Same-cycle hazard on reg 7
      cycle(1, 7, 32'h1, 0, 0, 0);
      @(negedge clk);
      RegWrite = 1'b1; rd = 5'd7; WriteData = 32'h2; rs1 = 5'd7; rs2 = 5'd0; dbg_addr = 5'd7;
      #1;
      chk("hazard_pre_rd1", ReadData1, BYP ? 32'h2 : 32'h1);
      chk("hazard_pre_dbg", dbg_data, BYP ? 32'h2 : 32'h1);
      @(posedge clk);
      mem[7] = 32'h2; cnt = cnt + 1;
      cycle(0, 0, 32'h0, 7, 7, 7);
      chk("hazard_post_rd1", ReadData1, 32'h2);
      chk("hazard_post_rd2", ReadData2, 32'h2);

      // Randomized traffic, rs ports biased toward rd to exercise hazards
      for (int k = 0; k < 1000; k++) begin
         w  = int'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, 31));
         a  = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, 31));
         cycle(bit'($urandom_range(0, 1)), w, $urandom, r1, a,
               int'($urandom_range(0, 31)));
      end

      // Asynchronous reset between edges
      cycle(1, 3, 32'hA5A5A5A5, 0, 0, 0);
      cycle(0, 0, 32'h0, 3, 0, 0);
      chk("pre_async_rd1", ReadData1, 32'hA5A5A5A5);
      @(negedge clk);
      RegWrite = 1'b0; rs1 = 5'd3;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rd1", ReadData1, 32'h0);
      chk("async_count", {16'h0, wr_count}, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("after_rel_rd1", ReadData1, 32'h0);
      cycle(0, 0, 32'h0, 3, 1, 3);

      // Counter wrap through 65536 writes to reg 1
      for (int i = 0; i < 65536; i++) begin
         @(negedge clk);
         RegWrite = 1'b1; rd = 5'd1; WriteData = 32'(i);
         @(posedge clk);
         cnt = cnt + 1;
         if (i == 65534) begin
            #1 chk("count_ffff", {16'h0, wr_count}, cnt & 32'hFFFF);
         end
      end
      mem[1] = 32'd65535;
      #1 chk("count_wrap", {16'h0, wr_count}, 32'h0);
      @(negedge clk);
      RegWrite = 1'b0; rs1 = 5'd1;
      #1 chk("wrap_reg1", ReadData1, 32'd65535);
      cycle(0, 0, 32'h0, 1, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; register count is 2**ADDR_W (32).
REQ-003 Port clk  input  1  SHALL be the single clock; all register updates occur on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port RegWrite  input  1  SHALL be the write enable for the write port.
REQ-006 Port rs1  input  ADDR_W  SHALL be the read address for port 1 (ALU operand A).
REQ-007 Port rs2  input  ADDR_W  SHALL be the read address for port 2 (ALU operand B, register path).
REQ-008 Port rd  input  ADDR_W  SHALL be the write address.
REQ-009 Port WriteData  input  DATA_W  SHALL be the write data (ALU Res or memory load data).
REQ-010 Port ReadData1  output  DATA_W  SHALL return the contents of register rs1.
REQ-011 Port ReadData2  output  DATA_W  SHALL return the contents of register rs2.
REQ-012 Port dbg_addr  input  ADDR_W  SHALL be the debug read address.
REQ-013 Port dbg_data  output  DATA_W  SHALL return the contents of register dbg_addr.
REQ-014 Port wr_count  output  16  SHALL count committed writes to nonzero registers.

Function
REQ-015 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-016 Register 0 SHALL read as 0 on all read ports at all times; writes to rd=0 are discarded.
REQ-017 A write SHALL commit on the rising clk edge when RegWrite=1 and rd!=0; the new value is visible to reads from the cycle after the edge.
REQ-018 With RegWrite=0, no register and no counter SHALL change.
REQ-019 Read ports SHALL be combinational (zero-cycle latency) on address and storage; the single-cycle datapath depends on this.
REQ-020 rs1==rs2 SHALL return identical data on both ports.
REQ-021 wr_count SHALL increment by 1 per committed write (REQ-017); writes to rd=0 do not count.
REQ-022 wr_count SHALL wrap from 16'hFFFF to 16'h0000 without saturating or flagging.
REQ-023 Same-cycle read and write of the same nonzero address SHALL follow REQ-038 / REQ-039.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, clear every register to 0 and wr_count to 0.
REQ-025 While rst_n=0, ReadData1, ReadData2 and dbg_data SHALL read 0 and writes SHALL be ignored.
REQ-026 A write whose clk edge coincides with rst_n low SHALL be discarded.
REQ-027 Release of rst_n SHALL NOT itself modify state; the first write can commit on the first rising edge with rst_n=1.

Configuration
REQ-038 With macro REG_FILE_BYPASS_EN defined: when RegWrite=1, rd!=0 and rsN==rd (or dbg_addr==rd), the matching read port SHALL return WriteData combinationally in the same cycle (write-through forwarding).
REQ-039 Without REG_FILE_BYPASS_EN: those read ports SHALL return the old stored value until the commit edge; no forwarding logic is synthesised.
REQ-040 Bypass SHALL never apply to address 0 or while rst_n=0.

Verification
REQ-041 Reset: hold rst_n=0, preload nothing -> all 32 registers read 0 via rs1/rs2/dbg sweep; wr_count=0.
REQ-042 Write/read: RegWrite=1, rd=5, WriteData=32'hDEADBEEF, one edge -> rs1=5 gives 32'hDEADBEEF next cycle; wr_count=1.
REQ-043 x0: RegWrite=1, rd=0, WriteData=32'hFFFFFFFF -> rs2=0 reads 0; wr_count unchanged.
REQ-044 Same-cycle hazard: reg 7 holds 32'h1, write rd=7, WriteData=32'h2, rs1=7 before the edge -> ReadData1=32'h2 with REG_FILE_BYPASS_EN, 32'h1 without; both read 32'h2 after the edge.
REQ-045 Async reset mid-operation: reg 3=32'hA5A5A5A5, assert rst_n low between edges -> ReadData1 (rs1=3) drops to 0 before the next clk edge; wr_count=0.
REQ-046 Counter wrap: perform 65536 writes to rd=1 -> wr_count returns to 16'h0000; reg 1 holds the last WriteData.
